au_dispatch: RTL and testbench
==============================

// Module: au_dispatch
// PURPOSE
//   Bridges the microcode sequencer and the shared arithmetic unit (AU). Decodes ctl_a/b/d/e,
//   owns the 8-entry operand data bank (DB), launches AU ops and drives the sequencer's
//   continue_i input. Completion handshake uses au_start/au_done; a watchdog guards against a hung AU.
// PARAMETERS
//   W            16  data word width (DB entries, operands, result)
//   TIMEOUT_CYC  64  max BUSY cycles without au_done before abort (>=2)
// PORTS
//   clk          in   1   rising-edge clock
//   rst          in   1   reset, synchronous, active-high
//   seq_ready    in   1   sequencer READY; fields acted on only when 0
//   ctl_a        in   5   [4:3] write source (00 DATA_IN, 01 RESULT, 1x illegal); [2:0] addr_a
//   ctl_b        in   5   [0]=1: addr_b=addr_a+1 mod 8, [0]=0: addr_b=addr_a; [4:1] ignored
//   ctl_d        in   2   AU op: 00 ADD, 01 SUB, 10 MUL, 11 DIV
//   ctl_e        in   2   [1] START op, [0] WRITE DB[addr_a]
//   data_in      in   W   external load data
//   err_clr      in   1   clears sticky error flags
//   au_start     out  1   1-cycle launch pulse to AU
//   au_op        out  2   registered op code, stable while busy
//   au_opa       out  W   registered operand A (DB[addr_a]), stable while busy
//   au_opb       out  W   registered operand B (DB[addr_b]), stable while busy
//   au_done      in   1   AU completion strobe; au_result valid same cycle
//   au_result    in   W   AU result
//   continue_o   out  1   to sequencer continue_i; 1 = no op pending
//   busy         out  1   1 while in BUSY
//   result_o     out  W   last captured result register
//   err_busy     out  1   sticky: START received while busy
//   err_timeout  out  1   sticky: watchdog abort
//   err_src      out  1   sticky: WRITE with ctl_a[4:3]=1x
// BEHAVIOUR
//   - Reset: state IDLE, au_start=0, au_op/au_opa/au_opb=0, result_o=0, continue_o=1, busy=0,
//     all err_*=0, watchdog=0. DB contents NOT cleared. Reset mid-op aborts silently; late au_done ignored.
//   - act = !seq_ready. All ctl decoding gated by act.
//   - WRITE (act & ctl_e[0]): at edge, DB[addr_a] <= data_in (src 00) or result_o (src 01);
//     src 1x: no write, err_src<=1. Legal in any state.
//   - DB reads combinational; operand capture is read-before-write (same-instruction WRITE not seen).
//   - FSM IDLE->BUSY on act & ctl_e[1]: at that edge capture au_op<=ctl_d, au_opa, au_opb,
//     continue_o<=0, watchdog<=0. au_start=1 exactly the first BUSY cycle (launch cycle+1).
//   - BUSY: au_done sampled every BUSY cycle incl. first. On au_done: result_o<=au_result,
//     continue_o<=1, ->IDLE. Sequencer WAIT in cycle after START sees continue_o=0.
//   - Watchdog counts BUSY cycles; at TIMEOUT_CYC cycles without au_done: err_timeout<=1,
//     continue_o<=1, result_o unchanged, ->IDLE.
//   - START while BUSY: ignored (operands unchanged), err_busy<=1. START+au_done same cycle:
//     completion taken, new START ignored, err_busy<=1.
//   - err_clr clears all err_*; simultaneous set wins over clear. Errors never stall FSM.
//   - addr_b wraps: addr_a=7, b[0]=1 -> addr_b=0.
// TESTING
//   1 Load 5->DB0, 3->DB1, ADD (a=0,b0=1), AU model done 1 cycle after au_start -> DB2=8 via WRITE
//     src RESULT; continue_o low exactly launch+1 .. done cycle.
//   2 SUB/MUL same operands, AU latency 10 -> result_o 2 then 15; au_op/opa/opb stable all BUSY cycles.
//   3 AU never asserts done, TIMEOUT_CYC=64 -> err_timeout=1 on cycle 64 of BUSY, continue_o=1,
//     result_o unchanged; err_clr -> err_timeout=0.
//   4 Second START while BUSY (different operands) -> ignored, err_busy=1, original op completes.
//   5 DB7=0x1234, DB0=0x0001, MUL a=7 b0=1 -> au_opa=0x1234, au_opb=0x0001; WRITE src 10 -> no
//     DB change, err_src=1; fields with seq_ready=1 -> no action.
//   6 rst during BUSY then au_done -> IDLE, continue_o=1, result_o=0, DB contents preserved.

Source files
------------

// File: rtl/au_dispatch_if.sv
// au_dispatch_if: sequencer control fields and AU handshake bundled for the AU dispatcher.
interface au_dispatch_if #(parameter int W = 16);
   logic         seq_ready;
   logic [4:0]   ctl_a;
   logic [4:0]   ctl_b;
   logic [1:0]   ctl_d;
   logic [1:0]   ctl_e;
   logic [W-1:0] data_in;
   logic         err_clr;
   logic         au_start;
   logic [1:0]   au_op;
   logic [W-1:0] au_opa;
   logic [W-1:0] au_opb;
   logic         au_done;
   logic [W-1:0] au_result;
   logic         continue_o;
   logic         busy;
   logic [W-1:0] result_o;
   logic         err_busy;
   logic         err_timeout;
   logic         err_src;
   modport slave (
      input  seq_ready, ctl_a, ctl_b, ctl_d, ctl_e, data_in, err_clr, au_done, au_result,
      output au_start, au_op, au_opa, au_opb, continue_o, busy, result_o,
             err_busy, err_timeout, err_src
   );
   modport master (
      output seq_ready, ctl_a, ctl_b, ctl_d, ctl_e, data_in, err_clr, au_done, au_result,
      input  au_start, au_op, au_opa, au_opb, continue_o, busy, result_o,
             err_busy, err_timeout, err_src
   );
endinterface

// File: rtl/au_dispatch.sv
// au_dispatch: decodes sequencer ctl fields, owns the 8-entry operand bank and launches AU ops.
module au_dispatch #(
   parameter int W           = 16,
   parameter int TIMEOUT_CYC = 64
) (
   input logic         clk,
   input logic         rst,
   au_dispatch_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT_CYC);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t         state_q, state_d;
   logic           start_q, start_d;
   logic [1:0]     op_q, op_d;
   logic [W-1:0]   opa_q, opa_d;
   logic [W-1:0]   opb_q, opb_d;
   logic [W-1:0]   result_q, result_d;
   logic           cont_q, cont_d;
   logic [CW-1:0]  wd_q, wd_d;
   logic           err_busy_q, err_busy_d;
   logic           err_to_q, err_to_d;
   logic           err_src_q, err_src_d;
   logic [W-1:0]   db_q [8];
   logic           act, start_req, wr_req, set_busy, set_to;
   logic [2:0]     addr_a, addr_b;
   logic [W-1:0]   db_wdata;
   logic           unused_ctl_b;
   assign act          = !bus.seq_ready;
   assign addr_a       = bus.ctl_a[2:0];
   assign addr_b       = addr_a + {2'b00, bus.ctl_b[0]};
   assign start_req    = act & bus.ctl_e[1];
   assign wr_req       = act & bus.ctl_e[0];
   assign db_wdata     = bus.ctl_a[3] ? result_q : bus.data_in;
   assign unused_ctl_b = ^bus.ctl_b[4:1];
   always_comb begin
      state_d  = state_q;
      start_d  = 1'b0;
      op_d     = op_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      result_d = result_q;
      cont_d   = cont_q;
      wd_d     = wd_q;
      set_busy = 1'b0;
      set_to   = 1'b0;
      if (state_q == IDLE) begin
         if (start_req) begin
            state_d = BUSY;
            start_d = 1'b1;
            op_d    = bus.ctl_d;
            opa_d   = db_q[addr_a];
            opb_d   = db_q[addr_b];
            cont_d  = 1'b0;
            wd_d    = '0;
         end
      end else begin
         // a START arriving while busy is dropped even if the op completes this cycle
         set_busy = start_req;
         if (bus.au_done) begin
            result_d = bus.au_result;
            cont_d   = 1'b1;
            state_d  = IDLE;
         end else if (wd_q == CW'(TIMEOUT_CYC - 1)) begin
            set_to  = 1'b1;
            cont_d  = 1'b1;
            state_d = IDLE;
         end else begin
            wd_d = wd_q + CW'(1);
         end
      end
      err_busy_d = set_busy | (err_busy_q & !bus.err_clr);
      err_to_d   = set_to | (err_to_q & !bus.err_clr);
      err_src_d  = (wr_req & bus.ctl_a[4]) | (err_src_q & !bus.err_clr);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         start_q    <= 1'b0;
         op_q       <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         result_q   <= '0;
         cont_q     <= 1'b1;
         wd_q       <= '0;
         err_busy_q <= 1'b0;
         err_to_q   <= 1'b0;
         err_src_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         op_q       <= op_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         result_q   <= result_d;
         cont_q     <= cont_d;
         wd_q       <= wd_d;
         err_busy_q <= err_busy_d;
         err_to_q   <= err_to_d;
         err_src_q  <= err_src_d;
      end
   end
   // the bank survives reset; operands were read above before this write lands
   always_ff @(posedge clk) begin
      if (wr_req && !bus.ctl_a[4]) db_q[addr_a] <= db_wdata;
   end
   assign bus.au_start    = start_q;
   assign bus.au_op       = op_q;
   assign bus.au_opa      = opa_q;
   assign bus.au_opb      = opb_q;
   assign bus.continue_o  = cont_q;
   assign bus.busy        = (state_q == BUSY);
   assign bus.result_o    = result_q;
   assign bus.err_busy    = err_busy_q;
   assign bus.err_timeout = err_to_q;
   assign bus.err_src     = err_src_q;
endmodule

// File: tb/tb_au_dispatch.sv
// tb_au_dispatch: directed and randomized checks of au_dispatch against a behavioural bank/AU model.
module tb_au_dispatch;
   localparam int W  = 16;
   localparam int TO = 64;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [W-1:0] m_db [8];
   logic [W-1:0] m_res;
   logic         m_eb, m_et, m_es;
   au_dispatch_if #(.W(W)) bus ();
   au_dispatch #(.W(W), .TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   function automatic logic [W-1:0] au_f(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int unsigned r;
      if (op == 2'd0) r = a + b;
      else if (op == 2'd1) r = a - b;
      else if (op == 2'd2) r = a * b;
      else r = (b == 0) ? 32'hffff : a / b;
      return r[W-1:0];
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // inactive cycle: fields carry random junk that must be ignored while seq_ready=1
   task automatic idle();
      bus.seq_ready = 1'b1;
      bus.ctl_a     = 5'($urandom);
      bus.ctl_b     = 5'($urandom);
      bus.ctl_d     = 2'($urandom);
      bus.ctl_e     = 2'($urandom);
      bus.data_in   = W'($urandom);
      bus.err_clr   = 1'b0;
   endtask
   task automatic do_write(input logic [2:0] addr, input logic [1:0] src, input logic [W-1:0] d);
      bus.seq_ready = 1'b0;
      bus.ctl_a     = {src, addr};
      bus.ctl_e     = 2'b01;
      bus.data_in   = d;
      step();
      idle();
      if (src[1]) m_es = 1'b1;
      else m_db[addr] = src[0] ? m_res : d;
   endtask
   task automatic err_clear();
      bus.err_clr = 1'b1;
      step();
      idle();
      m_eb = 1'b0; m_et = 1'b0; m_es = 1'b0;
      chk("clr_eb", bus.err_busy, 0);
      chk("clr_et", bus.err_timeout, 0);
      chk("clr_es", bus.err_src, 0);
   endtask
   // done_at: BUSY cycle (1 = au_start cycle) carrying au_done, 0 = never; busy_k: cycle of a stray START
   task automatic run_op(input logic [1:0] op, input logic [2:0] a, input logic b0, input int done_at, input int busy_k);
      logic [2:0]   ab;
      logic [W-1:0] ea, eb, r;
      ab = a + {2'b00, b0};
      ea = m_db[a];
      eb = m_db[ab];
      chk("pre_cont", bus.continue_o, 1);
      chk("pre_busy", bus.busy, 0);
      bus.seq_ready = 1'b0;
      bus.ctl_a     = {2'b00, a};
      bus.ctl_b     = {4'b0000, b0};
      bus.ctl_d     = op;
      bus.ctl_e     = 2'b10;
      step();
      idle();
      for (int k = 1; k <= TO; k++) begin
         chk("busy", bus.busy, 1);
         chk("cont_low", bus.continue_o, 0);
         chk("au_start", bus.au_start, (k == 1) ? 1 : 0);
         chk("au_op", bus.au_op, op);
         chk("au_opa", bus.au_opa, ea);
         chk("au_opb", bus.au_opb, eb);
         chk("et_hold", bus.err_timeout, m_et);
         if (k == busy_k) begin
            bus.seq_ready = 1'b0;
            bus.ctl_a     = {2'b00, a ^ 3'd5};
            bus.ctl_b     = {4'b0000, ~b0};
            bus.ctl_d     = ~op;
            bus.ctl_e     = 2'b10;
            m_eb = 1'b1;
         end
         if (k == done_at) begin
            r = au_f(op, ea, eb);
            bus.au_done   = 1'b1;
            bus.au_result = r;
            m_res = r;
         end
         step();
         idle();
         bus.au_done   = 1'b0;
         bus.au_result = W'($urandom);
         if (k == done_at) begin
            chk("done_busy", bus.busy, 0);
            chk("done_cont", bus.continue_o, 1);
            chk("done_res", bus.result_o, m_res);
            chk("done_eb", bus.err_busy, m_eb);
            return;
         end
      end
      m_et = 1'b1;
      chk("to_err", bus.err_timeout, 1);
      chk("to_cont", bus.continue_o, 1);
      chk("to_busy", bus.busy, 0);
      chk("to_res", bus.result_o, m_res);
   endtask
   initial begin
      bus.au_done   = 1'b0;
      bus.au_result = '0;
      idle();
      m_res = '0; m_eb = 1'b0; m_et = 1'b0; m_es = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("rst_start", bus.au_start, 0);
      chk("rst_op", bus.au_op, 0);
      chk("rst_opa", bus.au_opa, 0);
      chk("rst_opb", bus.au_opb, 0);
      chk("rst_res", bus.result_o, 0);
      chk("rst_cont", bus.continue_o, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_eb", bus.err_busy, 0);
      chk("rst_et", bus.err_timeout, 0);
      chk("rst_es", bus.err_src, 0);
      for (int i = 0; i < 8; i++) do_write(3'(i), 2'b00, W'($urandom));
      // basic ADD, then write the result back through the RESULT source
      do_write(3'd0, 2'b00, 16'd5);
      do_write(3'd1, 2'b00, 16'd3);
      run_op(2'd0, 3'd0, 1'b1, 2, 0);
      chk("add_res", bus.result_o, 16'd8);
      do_write(3'd2, 2'b01, 16'hdead);
      run_op(2'd0, 3'd2, 1'b0, 2, 0);
      // long latency SUB and MUL
      run_op(2'd1, 3'd0, 1'b1, 11, 0);
      chk("sub_res", bus.result_o, 16'd2);
      run_op(2'd2, 3'd0, 1'b1, 11, 0);
      chk("mul_res", bus.result_o, 16'd15);
      // hung AU trips the watchdog
      run_op(2'd3, 3'd0, 1'b1, 0, 0);
      chk("to_res15", bus.result_o, 16'd15);
      err_clear();
      // stray START mid-op, then on the completion cycle itself
      run_op(2'd0, 3'd0, 1'b1, 6, 3);
      chk("eb_set", bus.err_busy, 1);
      err_clear();
      run_op(2'd1, 3'd1, 1'b0, 4, 4);
      chk("eb_same", bus.err_busy, 1);
      err_clear();
      // address wrap and illegal write source
      do_write(3'd7, 2'b00, 16'h1234);
      do_write(3'd0, 2'b00, 16'h0001);
      run_op(2'd2, 3'd7, 1'b1, 2, 0);
      do_write(3'd7, 2'b10, 16'hbeef);
      chk("es_set", bus.err_src, 1);
      run_op(2'd0, 3'd7, 1'b0, 1, 0);
      chk("db7_kept", bus.result_o, 16'h2468);
      err_clear();
      bus.seq_ready = 1'b1;
      bus.ctl_a     = 5'b10_100;
      bus.ctl_e     = 2'b11;
      step();
      chk("gate_busy", bus.busy, 0);
      chk("gate_es", bus.err_src, 0);
      idle();
      run_op(2'd0, 3'd4, 1'b0, 1, 0);
      bus.err_clr = 1'b1;
      do_write(3'd5, 2'b11, 16'h0);
      chk("set_over_clr", bus.err_src, 1);
      err_clear();
      // reset mid-op; a late au_done must be ignored and the bank kept
      bus.seq_ready = 1'b0;
      bus.ctl_a     = 5'b00_111;
      bus.ctl_b     = 5'b00001;
      bus.ctl_d     = 2'd2;
      bus.ctl_e     = 2'b10;
      step();
      idle();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.au_done   = 1'b1;
      bus.au_result = 16'h5a5a;
      step();
      bus.au_done = 1'b0;
      m_res = '0;
      chk("rst6_busy", bus.busy, 0);
      chk("rst6_cont", bus.continue_o, 1);
      chk("rst6_res", bus.result_o, 0);
      chk("rst6_opa", bus.au_opa, 0);
      run_op(2'd2, 3'd7, 1'b1, 3, 0);
      chk("rst6_db", bus.result_o, 16'h1234);
      // randomized mix
      for (int i = 0; i < 30; i++) begin
         do_write(3'($urandom), 2'($urandom), W'($urandom));
         run_op(2'($urandom), 3'($urandom), 1'($urandom), int'($urandom_range(1, 12)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0);
         chk("rnd_es", bus.err_src, m_es);
         chk("rnd_eb", bus.err_busy, m_eb);
         if (i % 10 == 9) err_clear();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
